// File: rtl/cam_param.sv
// ---------------------------------------------------------------------------
// cam_param
//
// Small parameterised content-addressable memory. Each entry holds
// {valid, key, data}. Commands (SEARCH / INSERT / DELETE / CLEAR) arrive on a
// valid/ready channel. Each accepted command produces exactly one response
// one cycle later. The response is held in a register until it is consumed.
//
// Ports
//   clk        : sole clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : command accepted when cmd_valid && cmd_ready
//   cmd_op     : 00 SEARCH, 01 INSERT, 10 DELETE, 11 CLEAR
//   cmd_key    : lookup / insert key
//   cmd_data   : insert payload (ignored for other ops)
//   rsp_valid  : response held
//   rsp_ready  : response consumed when rsp_valid && rsp_ready
//   rsp_hit    : key matched a valid entry
//   rsp_err    : INSERT missed while the table was full
//   rsp_index  : matched, allocated or zero index
//   rsp_data   : data of the matched entry, else 0
//   full       : every entry is valid
//   count      : number of valid entries
// ---------------------------------------------------------------------------
module cam_param #(
    parameter int KEY_W  = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic [IDX_W-1:0]  rsp_index,
    output logic [DATA_W-1:0] rsp_data,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } cmdOp_t;

    // Entry storage. Only the valid bits are reset; key/data contents are
    // meaningless while their valid bit is low.
    logic [DEPTH-1:0]  r_valid;
    logic [KEY_W-1:0]  r_key  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // Response register
    logic              r_rspValid;
    logic              r_rspHit;
    logic              r_rspErr;
    logic [IDX_W-1:0]  r_rspIndex;
    logic [DATA_W-1:0] r_rspData;

    // Combinational lookup results and next-state decisions
    cmdOp_t            w_op;
    logic              w_accept;
    logic              w_hit;
    logic [IDX_W-1:0]  w_hitIdx;
    logic              w_hasFree;
    logic [IDX_W-1:0]  w_freeIdx;
    logic              w_doUpdate;
    logic              w_doAlloc;
    logic              w_doDelete;
    logic              w_doClear;
    logic              w_nextHit;
    logic              w_nextErr;
    logic [IDX_W-1:0]  w_nextIndex;
    logic [DATA_W-1:0] w_nextData;

    assign w_op      = cmdOp_t'(cmd_op);
    assign cmd_ready = !r_rspValid || rsp_ready;
    assign w_accept  = cmd_valid && cmd_ready && !reset;

    // Match scan. Walking from the top index down lets the lowest matching
    // index win if a duplicate ever existed.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_key[i] == cmd_key)) begin
                w_hit    = 1'b1;
                w_hitIdx = IDX_W'(i);
            end
        end
    end

    // Lowest free slot, used for allocation on an INSERT miss.
    always_comb begin
        w_hasFree = 1'b0;
        w_freeIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_hasFree = 1'b1;
                w_freeIdx = IDX_W'(i);
            end
        end
    end

    // Decode the accepted command into storage actions and the response
    // it will produce. All lookups use state from before the accepting edge.
    always_comb begin
        w_doUpdate  = 1'b0;
        w_doAlloc   = 1'b0;
        w_doDelete  = 1'b0;
        w_doClear   = 1'b0;
        w_nextHit   = 1'b0;
        w_nextErr   = 1'b0;
        w_nextIndex = '0;
        w_nextData  = '0;
        case (w_op)
            OP_SEARCH: begin
                if (w_hit) begin
                    w_nextHit   = 1'b1;
                    w_nextIndex = w_hitIdx;
                    w_nextData  = r_data[w_hitIdx];
                end
            end
            OP_INSERT: begin
                if (w_hit) begin
                    w_doUpdate  = w_accept;
                    w_nextHit   = 1'b1;
                    w_nextIndex = w_hitIdx;
                    w_nextData  = r_data[w_hitIdx];
                end else if (w_hasFree) begin
                    w_doAlloc   = w_accept;
                    w_nextIndex = w_freeIdx;
                end else begin
                    w_nextErr   = 1'b1;
                end
            end
            OP_DELETE: begin
                if (w_hit) begin
                    w_doDelete  = w_accept;
                    w_nextHit   = 1'b1;
                    w_nextIndex = w_hitIdx;
                    w_nextData  = r_data[w_hitIdx];
                end
            end
            OP_CLEAR: begin
                w_doClear = w_accept;
            end
            default: begin
                w_doClear = 1'b0;
            end
        endcase
    end

    // Valid bits: the only part of the table that reset touches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_doClear) begin
            r_valid <= '0;
        end else if (w_doAlloc) begin
            r_valid[w_freeIdx] <= 1'b1;
        end else if (w_doDelete) begin
            r_valid[w_hitIdx] <= 1'b0;
        end
    end

    // Key/data payload. w_doUpdate/w_doAlloc are already gated by reset
    // through w_accept, so no reset branch is needed here.
    always_ff @(posedge clk) begin
        if (w_doAlloc) begin
            r_key[w_freeIdx]  <= cmd_key;
            r_data[w_freeIdx] <= cmd_data;
        end else if (w_doUpdate) begin
            r_data[w_hitIdx]  <= cmd_data;
        end
    end

    // Occupancy counter. Allocation only happens with a free slot and
    // deletion only on a hit, so the count cannot leave 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset || w_doClear) begin
            r_count <= '0;
        end else if (w_doAlloc) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_doDelete) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Response register: loads on accept, drops valid when consumed without
    // a replacement, otherwise holds every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rspValid <= 1'b0;
            r_rspHit   <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspIndex <= '0;
            r_rspData  <= '0;
        end else if (w_accept) begin
            r_rspValid <= 1'b1;
            r_rspHit   <= w_nextHit;
            r_rspErr   <= w_nextErr;
            r_rspIndex <= w_nextIndex;
            r_rspData  <= w_nextData;
        end else if (rsp_ready) begin
            r_rspValid <= 1'b0;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_hit   = r_rspHit;
    assign rsp_err   = r_rspErr;
    assign rsp_index = r_rspIndex;
    assign rsp_data  = r_rspData;
    assign count     = r_count;
    assign full      = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_cam_param.sv
// ---------------------------------------------------------------------------
// tb_cam_param
//
// Self-checking bench for cam_param at KEY_W=8, DATA_W=16, DEPTH=4.
// Directed scenarios are followed by a randomized command stream. Every
// response is compared against a table model that applies the command rules
// directly to plain arrays.
// ---------------------------------------------------------------------------
module tb_cam_param;

    localparam int KEY_W  = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 3;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [KEY_W-1:0]  cmd_key;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_err;
    logic [IDX_W-1:0]  rsp_index;
    logic [DATA_W-1:0] rsp_data;
    logic              full;
    logic [CNT_W-1:0]  count;

    int testCount = 0;
    int failCount = 0;

    // Reference table
    bit       mValid [DEPTH];
    int       mKey   [DEPTH];
    int       mData  [DEPTH];
    int       mCount;

    // Expected response of the most recent accepted command
    int       eHit;
    int       eErr;
    int       eIdx;
    int       eData;

    cam_param #(
        .KEY_W (KEY_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_key  (cmd_key),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_hit  (rsp_hit),
        .rsp_err  (rsp_err),
        .rsp_index(rsp_index),
        .rsp_data (rsp_data),
        .full     (full),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        mCount = 0;
    endtask

    // Apply one command to the table model and record the expected response.
    task automatic modelApply(input logic [1:0] op, input int key, input int data);
        int found;
        int freeSlot;
        found    = -1;
        freeSlot = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (found < 0 && mValid[i] && mKey[i] == key) found = i;
            if (freeSlot < 0 && !mValid[i]) freeSlot = i;
        end
        eHit = 0; eErr = 0; eIdx = 0; eData = 0;
        case (op)
            OP_SEARCH: if (found >= 0) begin
                eHit = 1; eIdx = found; eData = mData[found];
            end
            OP_INSERT: begin
                if (found >= 0) begin
                    eHit = 1; eIdx = found; eData = mData[found];
                    mData[found] = data;
                end else if (mCount == DEPTH) begin
                    eErr = 1;
                end else begin
                    eIdx = freeSlot;
                    mValid[freeSlot] = 1'b1;
                    mKey[freeSlot]   = key;
                    mData[freeSlot]  = data;
                    mCount++;
                end
            end
            OP_DELETE: if (found >= 0) begin
                eHit = 1; eIdx = found; eData = mData[found];
                mValid[found] = 1'b0;
                mCount--;
            end
            default: modelReset();
        endcase
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        checkOne({tag, "_hit"},   64'(rsp_hit),   64'(eHit));
        checkOne({tag, "_err"},   64'(rsp_err),   64'(eErr));
        checkOne({tag, "_index"}, 64'(rsp_index), 64'(eIdx));
        checkOne({tag, "_data"},  64'(rsp_data),  64'(eData));
        checkOne({tag, "_count"}, 64'(count),     64'(mCount));
        checkOne({tag, "_full"},  64'(full),      64'(mCount == DEPTH));
    endtask

    task automatic checkReset(input string tag);
        checkOne({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        checkOne({tag, "_hit"},   64'(rsp_hit),   64'd0);
        checkOne({tag, "_err"},   64'(rsp_err),   64'd0);
        checkOne({tag, "_index"}, 64'(rsp_index), 64'd0);
        checkOne({tag, "_data"},  64'(rsp_data),  64'd0);
        checkOne({tag, "_count"}, 64'(count),     64'd0);
        checkOne({tag, "_full"},  64'(full),      64'd0);
    endtask

    // Present one command with rsp_ready high, let it be accepted on the next
    // edge, then check its response #1 after that edge.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input int key, input int data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = KEY_W'(key);
        cmd_data  = DATA_W'(data);
        rsp_ready = 1'b1;
        #1;
        checkOne({tag, "_cmdReady"}, 64'(cmd_ready), 64'd1);
        modelApply(op, key, data);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput(tag);
    endtask

    // Stall the response for n cycles while a CLEAR is offered: it must not
    // be accepted and the response must not move.
    task automatic holdCheck(input string tag, input int n);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        for (int c = 0; c < n; c++) begin
            #1;
            checkOne({tag, "_cmdReadyLow"}, 64'(cmd_ready), 64'd0);
            @(posedge clk);
            #1;
            checkOutput({tag, "_held"});
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] rOp;
        int         rKey;
        int         rData;

        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_INSERT;
        cmd_key   = 8'h99;
        cmd_data  = 16'h9999;
        rsp_ready = 1'b1;
        modelReset();

        // Reset with a command pending: nothing may be accepted
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkReset("reset");
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checkOne("postResetReady", 64'(cmd_ready), 64'd1);

        // Basic allocation and search
        applyStimulus("ins11", OP_INSERT, 8'h11, 16'hAAAA);
        checkOne("ins11_idx0", 64'(rsp_index), 64'd0);
        applyStimulus("ins22", OP_INSERT, 8'h22, 16'hBBBB);
        checkOne("ins22_idx1", 64'(rsp_index), 64'd1);
        checkOne("count2", 64'(count), 64'd2);
        applyStimulus("srch22", OP_SEARCH, 8'h22, 0);
        checkOne("srch22_data", 64'(rsp_data), 64'hBBBB);

        // Fill, overflow, overwrite existing
        applyStimulus("ins33", OP_INSERT, 8'h33, 16'hCCCC);
        applyStimulus("ins44", OP_INSERT, 8'h44, 16'hDDDD);
        applyStimulus("ins55full", OP_INSERT, 8'h55, 16'h5555);
        checkOne("fullErr", 64'(rsp_err), 64'd1);
        checkOne("fullFlag", 64'(full), 64'd1);
        applyStimulus("ins11upd", OP_INSERT, 8'h11, 16'h1234);
        checkOne("updOldData", 64'(rsp_data), 64'hAAAA);
        applyStimulus("srch11new", OP_SEARCH, 8'h11, 0);
        checkOne("updNewData", 64'(rsp_data), 64'h1234);

        // Delete then reuse the hole
        applyStimulus("del22", OP_DELETE, 8'h22, 0);
        checkOne("del22_data", 64'(rsp_data), 64'hBBBB);
        applyStimulus("del22miss", OP_DELETE, 8'h22, 0);
        applyStimulus("ins66", OP_INSERT, 8'h66, 16'h6666);
        checkOne("ins66_idx1", 64'(rsp_index), 64'd1);

        // Backpressure on a search hit, then release with a new command
        applyStimulus("srchHold", OP_SEARCH, 8'h44, 0);
        holdCheck("stall3", 3);
        applyStimulus("release", OP_SEARCH, 8'h66, 0);

        // Back-to-back insert then search of the same key
        applyStimulus("del33", OP_DELETE, 8'h33, 0);
        applyStimulus("ins77", OP_INSERT, 8'h77, 16'h7777);
        applyStimulus("srch77", OP_SEARCH, 8'h77, 0);
        checkOne("srch77_idx2", 64'(rsp_index), 64'd2);
        checkOne("srch77_hit", 64'(rsp_hit), 64'd1);

        // Randomized stream over a small key space to force hits and fills
        for (int n = 0; n < 300; n++) begin
            rOp   = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
            rKey  = int'($urandom_range(8'h10, 8'h16));
            rData = int'($urandom_range(0, 16'hFFFF));
            applyStimulus("rand", rOp, rKey, rData);
            if ($urandom_range(0, 9) == 0) holdCheck("randStall", int'($urandom_range(1, 2)));
        end

        // Clear, then reset during a held response
        applyStimulus("clear", OP_CLEAR, 0, 0);
        applyStimulus("srchAfterClr", OP_SEARCH, 8'h11, 0);
        applyStimulus("ins88", OP_INSERT, 8'h88, 16'h8888);
        applyStimulus("srch88", OP_SEARCH, 8'h88, 0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_INSERT;
        cmd_key   = 8'h99;
        cmd_data  = 16'h9999;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        checkReset("midReset");
        reset     = 1'b0;
        cmd_valid = 1'b0;
        modelReset();
        #1;
        checkOne("midResetReady", 64'(cmd_ready), 64'd1);
        applyStimulus("srch88gone", OP_SEARCH, 8'h88, 0);
        checkOne("srch88gone_hit", 64'(rsp_hit), 64'd0);
        applyStimulus("srch99gone", OP_SEARCH, 8'h99, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
